// File: rtl/rifl_lock_pkg.sv
// Shared types and sync-header helpers for the receive block-lock logic.
package rifl_lock_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    WAIT,
    LOCKED
  } lock_state_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  function automatic logic is_valid_sh(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// Block-lock monitor: hunts for sync-header alignment via gearbox slips and reports channel_good.
// Outputs are registered (one cycle after the deciding header); no backpressure, headers are strobed by rx_header_valid.
module rx_block_lock
  import rifl_lock_pkg::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVLD_MAX   = 16,
  parameter int SLIP_WAIT      = 32,
  parameter int LOSS_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                rx_header,
  input  logic                      rx_header_valid,
  output logic                      slip,
  output logic                      channel_good,
  output logic [LOSS_CNT_WIDTH-1:0] lock_loss_cnt
);

  localparam int SHW = $clog2(SH_CNT_MAX + 1);
  localparam int IVW = $clog2(SH_INVLD_MAX + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);

  localparam logic [SHW-1:0] SH_LAST   = SHW'(SH_CNT_MAX - 1);
  localparam logic [IVW-1:0] INV_LAST  = IVW'(SH_INVLD_MAX - 1);
  localparam logic [WTW-1:0] WAIT_LAST = WTW'(SLIP_WAIT - 1);

  if (SLIP_WAIT < 1 || SH_INVLD_MAX > SH_CNT_MAX) begin : g_param_check
    $error("rx_block_lock: need SLIP_WAIT >= 1 and SH_INVLD_MAX <= SH_CNT_MAX");
  end

  lock_state_t    state;
  logic [SHW-1:0] sh_cnt;
  logic [IVW-1:0] invld_cnt;
  logic [WTW-1:0] wait_cnt;
  logic           hdr_ok;

  always_comb hdr_ok = is_valid_sh(rx_header);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      sh_cnt        <= '0;
      invld_cnt     <= '0;
      wait_cnt      <= '0;
      slip          <= 1'b0;
      channel_good  <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      slip <= 1'b0;
      unique case (state)
        HUNT: begin
          if (rx_header_valid) begin
            if (!hdr_ok) begin
              sh_cnt <= '0;
              slip   <= 1'b1;
              state  <= SLIP;
            end else if (sh_cnt == SH_LAST) begin
              sh_cnt       <= '0;
              invld_cnt    <= '0;
              channel_good <= 1'b1;
              state        <= LOCKED;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
            end
          end
        end
        SLIP: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Gearbox is settling; every header in here is meaningless.
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            sh_cnt <= '0;
            state  <= HUNT;
          end
        end
        LOCKED: begin
          if (rx_header_valid) begin
            // Loss is checked first so it wins over a coincident window end.
            if (!hdr_ok && invld_cnt == INV_LAST) begin
              sh_cnt       <= '0;
              invld_cnt    <= '0;
              slip         <= 1'b1;
              channel_good <= 1'b0;
              state        <= SLIP;
              if (lock_loss_cnt != {LOSS_CNT_WIDTH{1'b1}})
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end else if (sh_cnt == SH_LAST) begin
              sh_cnt    <= '0;
              invld_cnt <= '0;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
              if (!hdr_ok) invld_cnt <= invld_cnt + 1'b1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock against a cycle-level behavioural model of the lock rules.
module tb_rx_block_lock;

  localparam int N_LOCK  = 64;
  localparam int N_INV   = 16;
  localparam int N_WAIT  = 32;
  localparam int LW      = 16;

  logic          clk;
  logic          rst_n;
  logic [1:0]    rx_header;
  logic          rx_header_valid;
  logic          slip;
  logic          channel_good;
  logic [LW-1:0] lock_loss_cnt;

  int n_cmp;
  int n_fail;

  // Reference model state: plain counters of what the rules talk about.
  bit m_locked;
  bit m_slip;
  int m_run;
  int m_win;
  int m_err;
  int m_blind;
  int m_losses;

  rx_block_lock #(
    .SH_CNT_MAX    (N_LOCK),
    .SH_INVLD_MAX  (N_INV),
    .SLIP_WAIT     (N_WAIT),
    .LOSS_CNT_WIDTH(LW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_header      (rx_header),
    .rx_header_valid(rx_header_valid),
    .slip           (slip),
    .channel_good   (channel_good),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_locked = 0; m_slip = 0; m_run = 0; m_win = 0; m_err = 0; m_blind = 0; m_losses = 0;
  endfunction

  function automatic void start_slip();
    m_slip  = 1;
    // One SLIP cycle plus SLIP_WAIT settling cycles during which headers are ignored.
    m_blind = N_WAIT + 1;
  endfunction

  function automatic void model_step(input logic [1:0] h, input logic v);
    bit good;
    good   = (h == 2'b01) || (h == 2'b10);
    m_slip = 0;
    if (m_blind > 0) begin
      m_blind--;
    end else if (v) begin
      if (!m_locked) begin
        if (good) begin
          m_run++;
          if (m_run == N_LOCK) begin
            m_locked = 1; m_run = 0; m_win = 0; m_err = 0;
          end
        end else begin
          m_run = 0;
          start_slip();
        end
      end else begin
        m_win++;
        if (!good) m_err++;
        if (m_err == N_INV) begin
          m_locked = 0; m_win = 0; m_err = 0; m_run = 0;
          if (m_losses < (1 << LW) - 1) m_losses++;
          start_slip();
        end else if (m_win == N_LOCK) begin
          m_win = 0; m_err = 0;
        end
      end
    end
  endfunction

  task automatic cyc(input logic [1:0] h, input logic v);
    rx_header       = h;
    rx_header_valid = v;
    @(posedge clk);
    model_step(h, v);
    #1;
  endtask

  task automatic do_reset();
    rx_header = 2'b00; rx_header_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_header = 2'b11; rx_header_valid = 1'b1;
    #2;
    n_cmp++;
    if ({slip, channel_good, lock_loss_cnt} !== {1'b0, 1'b0, {LW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: slip=%b good=%b loss=%0d, want 0/0/0", slip, channel_good, lock_loss_cnt);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < N_LOCK; i++) begin
      cyc(2'b01, 1'b1);
      n_cmp++;
      if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
        n_fail++;
        $display("FAIL lock hdr %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                 i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
      end
    end
    n_cmp++;
    if (channel_good !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_after_64: good=%b, want 1", channel_good);
    end
  endtask

  task automatic test_early_error();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(2'b10, 1'b1);
    cyc(2'b11, 1'b1);
    n_cmp++;
    if (slip !== 1'b1) begin
      n_fail++;
      $display("FAIL early_slip_rise: slip=%b, want 1", slip);
    end
    for (int i = 0; i < N_WAIT + N_LOCK + 1; i++) begin
      if (i < N_WAIT) cyc(2'b00, 1'b1);
      else cyc((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
      n_cmp++;
      if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
        n_fail++;
        $display("FAIL early_error cyc %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                 i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
      end
    end
    n_cmp++;
    if (channel_good !== 1'b1) begin
      n_fail++;
      $display("FAIL early_relock: good=%b, want 1", channel_good);
    end
  endtask

  task automatic test_loss();
    bit bad[40];
    int k;
    test_lock();
    foreach (bad[i]) bad[i] = 0;
    k = 0;
    while (k < N_INV) begin
      int p;
      p = $urandom_range(39, 0);
      if (!bad[p]) begin bad[p] = 1; k++; end
    end
    for (int i = 0; i < 40; i++) begin
      cyc(bad[i] ? (($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11) : 2'b01, 1'b1);
      n_cmp++;
      if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
        n_fail++;
        $display("FAIL loss cyc %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                 i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
      end
    end
    n_cmp++;
    if (lock_loss_cnt !== LW'(1)) begin
      n_fail++;
      $display("FAIL loss_count: loss=%0d, want 1", lock_loss_cnt);
    end
  endtask

  task automatic test_tolerated();
    test_lock();
    for (int w = 0; w < 3; w++) begin
      bit bad[N_LOCK];
      int k;
      foreach (bad[i]) bad[i] = 0;
      k = 0;
      while (k < N_INV - 1) begin
        int p;
        p = $urandom_range(N_LOCK - 1, 0);
        if (!bad[p]) begin bad[p] = 1; k++; end
      end
      for (int i = 0; i < N_LOCK; i++) begin
        cyc(bad[i] ? 2'b11 : 2'b10, 1'b1);
        n_cmp++;
        if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
          n_fail++;
          $display("FAIL tolerated win %0d hdr %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                   w, i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
        end
      end
    end
    n_cmp++;
    if ({channel_good, lock_loss_cnt} !== {1'b1, {LW{1'b0}}}) begin
      n_fail++;
      $display("FAIL tolerated_end: good=%b loss=%0d, want 1/0", channel_good, lock_loss_cnt);
    end
  endtask

  task automatic test_boundary();
    // Continues from a window boundary left by test_tolerated.
    for (int i = 0; i < N_LOCK; i++) begin
      cyc((i >= N_LOCK - N_INV) ? 2'b00 : 2'b01, 1'b1);
      n_cmp++;
      if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
        n_fail++;
        $display("FAIL boundary hdr %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                 i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
      end
    end
    n_cmp++;
    if ({slip, channel_good, lock_loss_cnt} !== {1'b1, 1'b0, LW'(1)}) begin
      n_fail++;
      $display("FAIL boundary_loss: slip=%b good=%b loss=%0d, want 1/0/1", slip, channel_good, lock_loss_cnt);
    end
  endtask

  task automatic test_strobe_gaps();
    int sent;
    do_reset();
    sent = 0;
    for (int i = 0; i < 400 && sent < N_LOCK; i++) begin
      if ($urandom_range(2, 0) == 0) begin
        cyc(2'b11, 1'b0);
      end else begin
        cyc(2'b01, 1'b1);
        sent++;
      end
      n_cmp++;
      if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
        n_fail++;
        $display("FAIL strobe_gaps cyc %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                 i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
      end
    end
    n_cmp++;
    if (channel_good !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_gaps_lock: good=%b, want 1", channel_good);
    end
  endtask

  task automatic test_async_reset();
    test_loss();
    for (int i = 0; i < N_WAIT + 1 + N_LOCK; i++) cyc(2'b01, 1'b1);
    n_cmp++;
    if ({channel_good, lock_loss_cnt} !== {1'b1, LW'(1)}) begin
      n_fail++;
      $display("FAIL async_pre_locked: good=%b loss=%0d, want 1/1", channel_good, lock_loss_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({slip, channel_good, lock_loss_cnt} !== {1'b0, 1'b0, {LW{1'b0}}}) begin
      n_fail++;
      $display("FAIL async_locked: slip=%b good=%b loss=%0d, want 0/0/0", slip, channel_good, lock_loss_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2'b01, 1'b1);
    cyc(2'b11, 1'b1);
    n_cmp++;
    if (slip !== 1'b1) begin
      n_fail++;
      $display("FAIL async_slip_setup: slip=%b, want 1", slip);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({slip, channel_good, lock_loss_cnt} !== {1'b0, 1'b0, {LW{1'b0}}}) begin
      n_fail++;
      $display("FAIL async_slip: slip=%b good=%b loss=%0d, want 0/0/0", slip, channel_good, lock_loss_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N_LOCK; i++) begin
      cyc(2'b10, 1'b1);
      n_cmp++;
      if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
        n_fail++;
        $display("FAIL async_relock hdr %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                 i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
      end
    end
  endtask

  task automatic test_random();
    int err_pct;
    bit prev_slip;
    int last_slip;
    do_reset();
    prev_slip = 0;
    last_slip = -1000;
    for (int i = 0; i < 6000; i++) begin
      // Sweep the error density so both steady lock and repeated loss occur.
      err_pct = ((i / 1000) % 3 == 0) ? 1 : (((i / 1000) % 3 == 1) ? 12 : 30);
      cyc(($urandom_range(99, 0) < err_pct) ? (($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11)
                                             : (($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10),
          $urandom_range(9, 0) != 0);
      n_cmp++;
      if ({slip, channel_good, lock_loss_cnt} !== {m_slip, m_locked, LW'(m_losses)}) begin
        n_fail++;
        $display("FAIL random cyc %0d: slip=%b good=%b loss=%0d, want %b/%b/%0d",
                 i, slip, channel_good, lock_loss_cnt, m_slip, m_locked, m_losses);
      end
      if (slip === 1'b1) begin
        n_cmp++;
        if (prev_slip || (i - last_slip) < N_WAIT + 2) begin
          n_fail++;
          $display("FAIL slip_spacing cyc %0d: gap=%0d, want >= %0d", i, i - last_slip, N_WAIT + 2);
        end
        last_slip = i;
      end
      prev_slip = (slip === 1'b1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rx_header = 2'b00;
    rx_header_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_early_error();
    test_loss();
    test_tolerated();
    test_boundary();
    test_strobe_gaps();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
